// File: rtl/credit_link_pkg.sv
// Shared types, defaults and helpers for the credit-based link receiver.
// The link starts in ST_INIT to hand out its initial credits, then stays in ST_RUN.
package credit_link_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } link_state_e;

  // Counters must be able to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/credit_link_fifo.sv
// First-word-fall-through FIFO with occupancy-derived full/empty.
// A push into a full FIFO is accepted only when a pop frees the head in the same cycle.
module credit_link_fifo
  import credit_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop_req,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy,
  output logic             pop,
  output logic             drop
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             full;
  logic             empty;
  logic             push;

  always_comb begin
    empty  = (occ_q == '0);
    full   = (occ_q == CNT_W'(DEPTH));
    pop    = !empty && pop_req;
    push   = push_req && (!full || pop);
    drop   = push_req && full && !pop;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    // Pointers are exactly log2(DEPTH) bits, so the increment wraps by itself.
    if (pop) begin
      head_d = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
    end
    if (push && !pop) begin
      occ_d = occ_q + 1'b1;
    end else if (pop && !push) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[tail_q] <= wr_data;
    end
  end

  // Stale storage is masked so the head word reads as zero whenever nothing is held.
  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[head_q];
  assign occupancy = occ_q;

endmodule

// File: rtl/credit_link_rx.sv
// Receive endpoint of a valid-only credit link: issues DEPTH initial credits,
// then buffers words and returns one registered credit per word handed downstream.
module credit_link_rx
  import credit_link_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             credit_return,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic [CNT_W-1:0] occupancy,
  output logic             init_done,
  output logic             overflow,
  output logic             protocol_err
);

  link_state_e      state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic             credit_q, credit_d;
  logic             init_done_q, init_done_d;
  logic             overflow_q, overflow_d;
  logic             perr_q, perr_d;
  logic             run;
  logic             fifo_pop;
  logic             fifo_drop;

  assign run = (state_q == ST_RUN);

  credit_link_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_req  (in_valid && run),
    .wr_data   (in_data),
    .pop_req   (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .occupancy (occupancy),
    .pop       (fifo_pop),
    .drop      (fifo_drop)
  );

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    credit_d    = 1'b0;
    overflow_d  = overflow_q || fifo_drop;
    perr_d      = perr_q || (in_valid && !run);
    case (state_q)
      ST_INIT: begin
        if (init_cnt_q == CNT_W'(DEPTH)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end else begin
          init_cnt_d = init_cnt_q + 1'b1;
          credit_d   = 1'b1;
        end
      end
      ST_RUN: begin
        // At most one pop per cycle, so one registered pulse per pop suffices.
        credit_d = fifo_pop;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
      credit_q    <= 1'b0;
      overflow_q  <= 1'b0;
      perr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      credit_q    <= credit_d;
      overflow_q  <= overflow_d;
      perr_q      <= perr_d;
    end
  end

  assign credit_return = credit_q;
  assign init_done     = init_done_q;
  assign overflow      = overflow_q;
  assign protocol_err  = perr_q;

endmodule

// File: tb/tb_credit_link_rx.sv
// Self-checking bench for credit_link_rx: directed table, corner sequences and
// randomized traffic against a queue-based reference model.
module tb_credit_link_rx;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_ready = 1'b0;
  logic             credit_return;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;
  logic             init_done;
  logic             overflow;
  logic             protocol_err;

  always #5 clk = ~clk;

  credit_link_rx #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .credit_return (credit_return),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .occupancy     (occupancy),
    .init_done     (init_done),
    .overflow      (overflow),
    .protocol_err  (protocol_err)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: words held, edges since reset release, sticky flags.
  byte unsigned m_q[$];
  int           m_cyc;
  bit           m_ovf, m_perr, m_credit, m_done;
  int           credit_cnt, pop_cnt;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       rdy;
    logic       ev;
    logic [7:0] ed;
    logic [2:0] eocc;
    logic       ecr;
    logic       eovf;
  } vec_t;

  vec_t vec [14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_model(input string tag);
    chk({tag, " out_valid"}, 32'(out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) chk({tag, " out_data"}, 32'(out_data), 32'(m_q[0]));
    chk({tag, " occupancy"}, 32'(occupancy), 32'(m_q.size()));
    chk({tag, " credit_return"}, 32'(credit_return), 32'(m_credit));
    chk({tag, " init_done"}, 32'(init_done), 32'(m_done));
    chk({tag, " overflow"}, 32'(overflow), 32'(m_ovf));
    chk({tag, " protocol_err"}, 32'(protocol_err), 32'(m_perr));
  endtask

  // Advance the model by the rules for one clock edge, then clock the DUT and compare.
  task automatic step(input string tag, input bit verbose);
    bit pop, acc;
    byte unsigned popped;
    pop = (m_q.size() > 0) && out_ready;
    acc = 1'b0;
    popped = 8'h00;
    m_cyc++;
    m_credit = (m_cyc <= DEPTH) ? 1'b1 : pop;
    if (in_valid) begin
      if (!m_done) m_perr = 1'b1;
      else if (m_q.size() == DEPTH && !pop) m_ovf = 1'b1;
      else acc = 1'b1;
    end
    if (pop) begin
      popped = m_q.pop_front();
      pop_cnt++;
    end
    if (acc) m_q.push_back(in_data);
    m_done = (m_cyc >= DEPTH + 1);
    @(posedge clk);
    #1;
    if (credit_return) credit_cnt++;
    if (verbose && (pop || in_valid))
      $display("%s cyc=%0d push=%0b data=0x%02h accepted=%0b pop=%0b popped=0x%02h occ=%0d",
               tag, m_cyc, in_valid, in_data, acc, pop, popped, occupancy);
    compare_model(tag);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    chk({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, " rst out_data"}, 32'(out_data), 32'd0);
    chk({tag, " rst occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, " rst credit_return"}, 32'(credit_return), 32'd0);
    chk({tag, " rst init_done"}, 32'(init_done), 32'd0);
    chk({tag, " rst overflow"}, 32'(overflow), 32'd0);
    chk({tag, " rst protocol_err"}, 32'(protocol_err), 32'd0);
    $display("%s: reset asserted, outputs cleared", tag);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_cyc = 0;
    m_ovf = 1'b0;
    m_perr = 1'b0;
    m_credit = 1'b0;
    m_done = 1'b0;
    credit_cnt = 0;
    pop_cnt = 0;
  endtask

  initial begin
    //            iv    id     rdy   ev    ed     occ   cr    ovf
    vec[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b0};
    vec[1]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b0};
    vec[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0};
    vec[3]  = '{1'b1, 8'h01, 1'b0, 1'b1, 8'h01, 3'd1, 1'b0, 1'b0};
    vec[4]  = '{1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 3'd2, 1'b0, 1'b0};
    vec[5]  = '{1'b1, 8'h03, 1'b0, 1'b1, 8'h01, 3'd3, 1'b0, 1'b0};
    vec[6]  = '{1'b1, 8'h04, 1'b0, 1'b1, 8'h01, 3'd4, 1'b0, 1'b0};
    vec[7]  = '{1'b1, 8'h10, 1'b1, 1'b1, 8'h02, 3'd4, 1'b1, 1'b0};
    vec[8]  = '{1'b1, 8'h05, 1'b0, 1'b1, 8'h02, 3'd4, 1'b0, 1'b1};
    vec[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h03, 3'd3, 1'b1, 1'b1};
    vec[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h04, 3'd2, 1'b1, 1'b1};
    vec[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 3'd1, 1'b1, 1'b1};
    vec[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b1, 1'b1};
    vec[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1};

    #2;
    do_reset("rst0");

    // Init: credits on cycles 1..DEPTH, init_done from DEPTH+1.
    for (int k = 1; k <= DEPTH + 2; k++) begin
      step("init", 1'b0);
      chk("init credit_return", 32'(credit_return), 32'(k <= DEPTH));
      chk("init init_done", 32'(init_done), 32'(k >= DEPTH + 1));
      $display("init cycle %0d: credit_return=%0b init_done=%0b occ=%0d",
               k, credit_return, init_done, occupancy);
    end

    // Directed table: single word, fill, full push+pop, overflow, drain.
    for (int i = 0; i < 14; i++) begin
      in_valid  = vec[i].iv;
      in_data   = vec[i].id;
      out_ready = vec[i].rdy;
      step("vec", 1'b0);
      $display("vec %0d: in_valid=%0b in_data=0x%02h out_ready=%0b -> out_valid=%0b out_data=0x%02h occ=%0d credit=%0b ovf=%0b",
               i, vec[i].iv, vec[i].id, vec[i].rdy, out_valid, out_data, occupancy,
               credit_return, overflow);
      chk("vec out_valid", 32'(out_valid), 32'(vec[i].ev));
      if (vec[i].ev) chk("vec out_data", 32'(out_data), 32'(vec[i].ed));
      chk("vec occupancy", 32'(occupancy), 32'(vec[i].eocc));
      chk("vec credit_return", 32'(credit_return), 32'(vec[i].ecr));
      chk("vec overflow", 32'(overflow), 32'(vec[i].eovf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("vec credit total", 32'(credit_cnt), 32'(DEPTH + 6));

    // Word arriving during INIT is dropped and flagged.
    do_reset("rst1");
    step("perr", 1'b0);
    in_valid = 1'b1;
    in_data  = 8'h77;
    step("perr", 1'b1);
    in_valid = 1'b0;
    repeat (DEPTH + 2) step("perr", 1'b0);
    chk("perr protocol_err", 32'(protocol_err), 32'd1);
    chk("perr occupancy", 32'(occupancy), 32'd0);
    chk("perr init credits", 32'(credit_cnt), 32'(DEPTH));
    in_valid  = 1'b1;
    in_data   = 8'h33;
    out_ready = 1'b0;
    step("perr", 1'b1);
    in_valid = 1'b0;
    chk("perr first word", 32'(out_data), 32'h33);

    // Asynchronous reset mid-stream with occupancy 3 and overflow set.
    do_reset("rst2");
    repeat (DEPTH + 1) step("mid", 1'b0);
    for (int i = 1; i <= DEPTH + 1; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step("mid", 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step("mid", 1'b1);
    out_ready = 1'b0;
    chk("mid pre-reset occupancy", 32'(occupancy), 32'd3);
    chk("mid pre-reset credit", 32'(credit_return), 32'd1);
    #2;
    do_reset("rst3");
    repeat (DEPTH + 2) step("reinit", 1'b0);
    chk("reinit credits", 32'(credit_cnt), 32'(DEPTH));
    chk("reinit init_done", 32'(init_done), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      step("rand", 1'b1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 1) step("drain", 1'b1);
    chk("rand credit total", 32'(credit_cnt), 32'(DEPTH + pop_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
